// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-stage buffer.
//   NOP_INSTR      : encoding driven on out_instr for a bubble (sll $0,$0,0)
//   *_W_DEF        : default field widths
//   ENTRY_W        : width of one packed {pc, instr, data} entry at default widths
//   m_src_e        : where the main register takes its next contents from
package pipe_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF  = 128;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned ENTRY_W     = PC_W_DEF + INSTR_W_DEF + DATA_W_DEF;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    M_HOLD,     // main full and stalled
    M_FROM_S,   // skid entry promoted into main
    M_FROM_IN,  // fresh input goes straight into main
    M_DRAIN     // main empties (fired or was empty) with nothing to refill
  } m_src_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: W-bit payload register plus its valid flag.
//   clk, reset : clock and synchronous active-high reset (clears payload and valid)
//   load_i     : capture d_i into the payload register
//   d_i        : payload to capture
//   valid_d_i  : next value of the valid flag (applied every cycle)
//   q_o        : held payload
//   valid_o    : held valid flag
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned W = ENTRY_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  input  logic         valid_d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d_i;
      if (load_i) data_q <= d_i;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready
// handshake, synchronous flush and a 2-entry skid buffer (main M, skid S).
// in_ready is registered (~skid valid), so a downstream stall never reaches
// upstream combinationally; sustained throughput is one transfer per cycle.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : synchronous kill of both held entries
//   in_valid / in_ready   : upstream handshake; in_pc, in_instr, in_data payload
//   out_valid / out_ready : downstream handshake; out_pc, out_instr, out_data payload
//   stall_cnt, flush_cnt  : saturating statistics, built only when the macro
//                           PIPE_STAT_EN is defined, otherwise tied to zero
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned INSTR_W     = INSTR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int unsigned EW = PC_W + INSTR_W + DATA_W;

  logic [EW-1:0]      in_ent, m_q, s_q, m_d;
  logic               m_v_q, s_v_q, m_v_d, s_v_d;
  logic               m_ld, s_ld;
  logic               in_fire, m_open;
  m_src_e             m_src;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic [DATA_W-1:0]  m_data;

  assign in_ent  = {in_pc, in_instr, in_data};
  assign in_fire = in_valid & ~s_v_q;
  assign m_open  = ~m_v_q | out_ready;

  // S only fills while M is stalled, so S is promoted before any new input
  // is considered; in_ready=0 whenever S is full keeps both from colliding.
  always_comb begin
    m_src = M_HOLD;
    if (m_open) begin
      if (s_v_q)        m_src = M_FROM_S;
      else if (in_fire) m_src = M_FROM_IN;
      else              m_src = M_DRAIN;
    end
  end

  always_comb begin
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    m_ld  = 1'b0;
    s_ld  = 1'b0;
    m_d   = s_q;
    case (m_src)
      M_FROM_S: begin
        m_ld  = 1'b1;
        m_d   = s_q;
        m_v_d = 1'b1;
        s_v_d = 1'b0;
      end
      M_FROM_IN: begin
        m_ld  = 1'b1;
        m_d   = in_ent;
        m_v_d = 1'b1;
      end
      M_DRAIN: m_v_d = 1'b0;
      M_HOLD: begin
        if (in_fire) begin
          s_ld  = 1'b1;
          s_v_d = 1'b1;
        end
      end
    endcase
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
      m_ld  = 1'b0;
      s_ld  = 1'b0;
    end
  end

  pipe_entry_reg #(.W(EW)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load_i    (m_ld),
    .d_i       (m_d),
    .valid_d_i (m_v_d),
    .q_o       (m_q),
    .valid_o   (m_v_q)
  );

  pipe_entry_reg #(.W(EW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load_i    (s_ld),
    .d_i       (in_ent),
    .valid_d_i (s_v_d),
    .q_o       (s_q),
    .valid_o   (s_v_q)
  );

  assign in_ready  = ~s_v_q;
  assign out_valid = m_v_q;
  assign {m_pc, m_instr, m_data} = m_q;

  if (ZERO_BUBBLE) begin : g_bubble
    assign out_pc    = m_v_q ? m_pc    : '0;
    assign out_instr = m_v_q ? m_instr : INSTR_W'(NOP_INSTR);
    assign out_data  = m_v_q ? m_data  : '0;
  end else begin : g_stale
    assign out_pc    = m_pc;
    assign out_instr = m_instr;
    assign out_data  = m_data;
  end

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (m_v_q && !out_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (m_v_q || s_v_q) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

`ifdef PIPE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]  in_pc = '0, in_instr = '0;
  logic [127:0] in_data = '0;

  // a: defaults, b: CNT_W=4, c: ZERO_BUBBLE=0 -- all share the same stimulus
  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [31:0]  a_out_pc, a_out_instr, b_out_pc, b_out_instr, c_out_pc, c_out_instr;
  logic [127:0] a_out_data, b_out_data, c_out_data;
  logic [15:0]  a_stall, a_flush, c_stall, c_flush;
  logic [3:0]   b_stall, b_flush;

  always #5 clk = ~clk;

  pipe_stage_buf dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr), .out_data(a_out_data),
    .stall_cnt(a_stall), .flush_cnt(a_flush));

  pipe_stage_buf #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr), .out_data(b_out_data),
    .stall_cnt(b_stall), .flush_cnt(b_flush));

  pipe_stage_buf #(.ZERO_BUBBLE(1'b0)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_pc(c_out_pc), .out_instr(c_out_instr), .out_data(c_out_data),
    .stall_cnt(c_stall), .flush_cnt(c_flush));

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [127:0] data;
  } ent_t;

  // Reference model: a FIFO of capacity 2 plus event tallies.
  ent_t        mq[$];
  int          exp_stall = 0, exp_flush = 0;
  logic [31:0] last_pc = '0;
  bit          last_known = 1'b0;
  int          n_checks = 0, n_fail = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int exp_cnt(input int v, input int mx);
    return STAT ? sat(v, mx) : 0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = $urandom();
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Advance one clock; the model consumes the inputs as they stand at the edge.
  task automatic tick(output bit fired);
    int   sz;
    bit   infire;
    ent_t e;
    sz     = mq.size();
    infire = in_valid && (sz < 2);
    e.pc = in_pc; e.instr = in_instr; e.data = in_data;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      exp_stall = 0; exp_flush = 0; last_pc = '0; last_known = 1'b1;
      infire = 1'b0;
    end else begin
      if (sz > 0 && !out_ready) exp_stall++;
      if (flush) begin
        if (sz > 0) exp_flush++;
        mq.delete();
        last_known = 1'b0;
        infire = 1'b0;
      end else begin
        if (sz > 0 && out_ready) void'(mq.pop_front());
        if (infire) mq.push_back(e);
        if (mq.size() > 0) begin last_pc = mq[0].pc; last_known = 1'b1; end
      end
    end
    fired = infire;
    #1;
  endtask

  task automatic do_reset();
    bit f;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, '0);
    tick(f);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bit f;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h100); tick(f);
    drive(1'b1, 32'h104); tick(f);
    drive(1'b1, 32'h108); tick(f);
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_full_ready: got %0b expected 0", a_in_ready); end
    reset = 1'b1; tick(f); reset = 1'b0; drive(1'b0, '0);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b expected 1", a_in_ready); end
    n_checks++; if (a_out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", a_out_instr); end
    n_checks++; if (a_out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", a_out_pc); end
    n_checks++; if (a_stall !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", a_stall); end
    n_checks++; if (a_flush !== 16'd0) begin n_fail++; $display("FAIL rst_flush_cnt: got %0d expected 0", a_flush); end
    n_checks++; if (c_out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_stale_pc: got %h expected 0", c_out_pc); end
  endtask

  task automatic test_streaming();
    bit f;
    logic [31:0] instrs[3];
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i));
      instrs[i] = in_instr;
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %0b expected 1", i, a_in_ready); end
      tick(f);
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b expected 1", i, a_out_valid); end
      n_checks++; if (a_out_pc !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, a_out_pc, 32'h3000 + 32'(4 * i)); end
      n_checks++; if (a_out_instr !== instrs[i]) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, a_out_instr, instrs[i]); end
    end
    drive(1'b0, '0); tick(f);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b expected 0", a_out_valid); end
  endtask

  task automatic test_stall();
    bit f;
    int k, idx;
    logic [31:0] src[3];
    src[0] = 32'h3000; src[1] = 32'h3004; src[2] = 32'h3008;
    do_reset();
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, src[k]);
      tick(f);
      if (f) k++;
    end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %0b expected 0", a_in_ready); end
    n_checks++; if (a_out_pc !== 32'h3000) begin n_fail++; $display("FAIL stall_head: got %h expected 3000", a_out_pc); end
    n_checks++; if (a_stall !== 16'(exp_cnt(4, 65535))) begin n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", a_stall, exp_cnt(4, 65535)); end
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 3) drive(1'b1, src[k]); else drive(1'b0, '0);
      if (a_out_valid) begin
        n_checks++; if (idx > 2 || a_out_pc !== src[idx % 3]) begin n_fail++; $display("FAIL stall_order[%0d]: got %h expected %h", idx, a_out_pc, src[idx % 3]); end
        idx++;
      end
      tick(f);
      if (f) k++;
    end
    n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL stall_delivered: got %0d expected 3", idx); end
  endtask

  task automatic test_flush();
    bit f;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h3000); tick(f);
    drive(1'b1, 32'h3004); tick(f);
    flush = 1'b1; drive(1'b1, 32'h3010); tick(f);
    flush = 1'b0; drive(1'b0, '0);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_out_instr !== 32'h0) begin n_fail++; $display("FAIL flush_instr: got %h expected 0", a_out_instr); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b expected 1", a_in_ready); end
    n_checks++; if (a_flush !== 16'(exp_cnt(1, 65535))) begin n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", a_flush, exp_cnt(1, 65535)); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(f);
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped[%0d]: got %0b expected 0", c, a_out_valid); end
    end
    flush = 1'b1; tick(f); flush = 1'b0;
    n_checks++; if (a_flush !== 16'(exp_cnt(1, 65535))) begin n_fail++; $display("FAIL flush_empty_cnt: got %0d expected %0d", a_flush, exp_cnt(1, 65535)); end
  endtask

  task automatic test_saturation();
    bit f;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h3000); tick(f);
    drive(1'b0, '0);
    for (int c = 0; c < 20; c++) tick(f);
    n_checks++; if (b_stall !== 4'(exp_cnt(20, 15))) begin n_fail++; $display("FAIL sat_cnt4: got %0d expected %0d", b_stall, exp_cnt(20, 15)); end
    n_checks++; if (a_stall !== 16'(exp_cnt(20, 65535))) begin n_fail++; $display("FAIL sat_cnt16: got %0d expected %0d", a_stall, exp_cnt(20, 65535)); end
  endtask

  task automatic test_stale_hold();
    bit f;
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h3000); tick(f);
    drive(1'b1, 32'h3004); tick(f);
    drive(1'b1, 32'h3008); tick(f);
    drive(1'b0, '0); tick(f);
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_valid: got %0b expected 0", c_out_valid); end
    n_checks++; if (c_out_pc !== 32'h3008) begin n_fail++; $display("FAIL stale_pc: got %h expected 3008", c_out_pc); end
    n_checks++; if (a_out_pc !== 32'h0) begin n_fail++; $display("FAIL bubble_pc: got %h expected 0", a_out_pc); end
  endtask

  task automatic test_random();
    bit   f, ev;
    ent_t h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(63) == 0);
      flush     = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(2) != 0);
      drive($urandom_range(3) != 0, $urandom());
      tick(f);
      reset = 1'b0;
      ev = (mq.size() > 0);
      h  = ev ? mq[0] : '0;
      n_checks++; if (a_out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, a_out_valid, ev); end
      n_checks++; if (a_in_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %0b expected %0b", c, a_in_ready, mq.size() < 2); end
      n_checks++; if ({a_out_pc, a_out_instr, a_out_data} !== h) begin n_fail++; $display("FAIL rnd_entry@%0d: got %h %h expected %h %h", c, a_out_pc, a_out_instr, h.pc, h.instr); end
      n_checks++; if ({b_out_valid, b_in_ready, b_out_pc, b_out_data} !== {ev, mq.size() < 2, h.pc, h.data}) begin n_fail++; $display("FAIL rnd_b@%0d: got pc %h expected %h", c, b_out_pc, h.pc); end
      if (ev) begin
        n_checks++; if ({c_out_valid, c_out_pc, c_out_instr, c_out_data} !== {1'b1, h}) begin n_fail++; $display("FAIL rnd_c@%0d: got pc %h expected %h", c, c_out_pc, h.pc); end
      end else if (last_known) begin
        n_checks++; if (c_out_pc !== last_pc) begin n_fail++; $display("FAIL rnd_stale@%0d: got %h expected %h", c, c_out_pc, last_pc); end
      end
      n_checks++; if (a_stall !== 16'(exp_cnt(exp_stall, 65535))) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0d expected %0d", c, a_stall, exp_cnt(exp_stall, 65535)); end
      n_checks++; if (a_flush !== 16'(exp_cnt(exp_flush, 65535))) begin n_fail++; $display("FAIL rnd_flush@%0d: got %0d expected %0d", c, a_flush, exp_cnt(exp_flush, 65535)); end
      n_checks++; if ({b_stall, b_flush} !== {4'(exp_cnt(exp_stall, 15)), 4'(exp_cnt(exp_flush, 15))}) begin n_fail++; $display("FAIL rnd_cnt4@%0d: got %0d/%0d expected %0d/%0d", c, b_stall, b_flush, exp_cnt(exp_stall, 15), exp_cnt(exp_flush, 15)); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_saturation();
    test_stale_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
